// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one bus read per PC value, with the PC held until IF/ID accepts the word.
// A redirect abandons the in-flight fetch by draining it, so the bus contract holds and stale data is dropped.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        flush,
  input  logic        idStall,
  output logic        instReq,
  output logic [31:0] instAddr,
  input  logic        instAck,
  input  logic        instRValid,
  input  logic [31:0] instRData,
  output logic        pcStall,
  output logic [31:0] instr,
  output logic        instrValid,
  output logic [31:0] instrPc,
  output logic        fetchAdEL
);

  typedef enum logic [2:0] {
    ISSUE,
    WAIT,
    HOLD,
    DRAIN_REQ,
    DRAIN_RESP
  } state_t;

  state_t      state;
  logic [31:0] addrReg;
  logic [31:0] instrReg;
  logic [31:0] pcReg;
  logic        adelReg;
  logic        misaligned;

  assign misaligned = (pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ISSUE;
      addrReg  <= '0;
      instrReg <= '0;
      pcReg    <= RESET_PC;
      adelReg  <= 1'b0;
    end else begin
      unique case (state)
        ISSUE: begin
          if (misaligned) begin
            // No bus access: the word is a synthetic zero flagged as AdEL.
            pcReg    <= pc;
            instrReg <= '0;
            adelReg  <= 1'b1;
            state    <= flush ? ISSUE : HOLD;
          end else begin
            addrReg <= pc;
            pcReg   <= pc;
            if (flush)        state <= instAck ? DRAIN_RESP : DRAIN_REQ;
            else if (instAck) state <= WAIT;
          end
        end
        WAIT: begin
          if (flush) begin
            // A response arriving together with the flush is consumed and dropped here.
            state <= instRValid ? ISSUE : DRAIN_RESP;
          end else if (instRValid) begin
            instrReg <= instRData;
            adelReg  <= 1'b0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (flush || !idStall) state <= ISSUE;
        end
        DRAIN_REQ: begin
          if (instAck) state <= DRAIN_RESP;
        end
        DRAIN_RESP: begin
          if (instRValid) state <= ISSUE;
        end
        default: state <= ISSUE;
      endcase
    end
  end

  always_comb begin
    instReq    = 1'b0;
    instAddr   = '0;
    pcStall    = 1'b1;
    instrValid = 1'b0;
    fetchAdEL  = 1'b0;
    instr      = instrReg;
    instrPc    = pcReg;
    if (rst) begin
      instr   = '0;
      instrPc = '0;
    end else begin
      unique case (state)
        ISSUE: begin
          if (!misaligned) begin
            instReq  = 1'b1;
            instAddr = pc;
          end
        end
        HOLD: begin
          instrValid = !flush;
          fetchAdEL  = adelReg && !flush;
          pcStall    = flush || idStall;
        end
        DRAIN_REQ: begin
          // Keep presenting the abandoned address until the bus takes it.
          instReq  = 1'b1;
          instAddr = addrReg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl: a PC register, a latency-varying memory and a scoreboard of
// instructions that must be delivered, checked by an independent monitor.
module tb_fetch_ctrl;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        flush;
  logic        idStall;
  logic        instReq;
  logic [31:0] instAddr;
  logic        instAck;
  logic        instRValid;
  logic [31:0] instRData;
  logic        pcStall;
  logic [31:0] instr;
  logic        instrValid;
  logic [31:0] instrPc;
  logic        fetchAdEL;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .pc(pc), .flush(flush), .idStall(idStall),
    .instReq(instReq), .instAddr(instAddr), .instAck(instAck),
    .instRValid(instRValid), .instRData(instRData), .pcStall(pcStall),
    .instr(instr), .instrValid(instrValid), .instrPc(instrPc), .fetchAdEL(fetchAdEL)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic        adel;
  } exp_t;

  pend_t pending[$];
  exp_t  expQ[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mode = 0;
  int accepts = 0;

  logic        sReq, sAck, sStall, sFlush, sRv, sRst;
  logic [31:0] sAddr;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h2408_0001;
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F96;
  endfunction

  function automatic exp_t mk(input logic [31:0] p);
    exp_t e;
    e.pc   = p;
    e.adel = (p[1:0] != 2'b00);
    e.word = e.adel ? 32'h0 : memWord(p);
    return e;
  endfunction

  function automatic logic [31:0] nextPc(input logic [31:0] p);
    int r;
    if (mode == 0) return p + 32'd4;
    r = $urandom_range(0, 15);
    if (r == 0) return p + 32'd2;
    if (r <= 2) return 32'hBFC0_0000 | (32'($urandom_range(0, 1023)) << 2);
    return p + 32'd4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One bus/PC cycle: inputs driven at the falling edge, models advanced just after the rising edge.
  task automatic step(input logic rstIn);
    @(negedge clk);
    rst     = rstIn;
    flush   = (mode == 1) && !rstIn && ($urandom_range(0, 11) == 0);
    idStall = (mode == 1) && ($urandom_range(0, 9) < 3);
    if (!rstIn && pending.size() > 0 && pending[0].due <= cyc &&
        (mode == 0 || $urandom_range(0, 2) != 0)) begin
      instRValid = 1'b1;
      instRData  = memWord(pending[0].addr);
    end else begin
      instRValid = 1'b0;
      instRData  = $urandom;
    end
    #1;
    instAck = instReq && (mode == 0 || $urandom_range(0, 1) == 1);
    sReq = instReq; sAck = instAck; sAddr = instAddr; sStall = pcStall;
    sFlush = flush; sRv = instRValid; sRst = rst;
    @(posedge clk);
    cyc++;
    #1;
    if (sRst) begin
      pending.delete();
      expQ.delete();
      pc = RST_PC;
      expQ.push_back(mk(pc));
    end else begin
      if (sRv) void'(pending.pop_front());
      if (sReq && sAck) begin
        pend_t n;
        n.addr = sAddr;
        n.due  = cyc + ((mode == 0) ? 0 : $urandom_range(0, 3));
        pending.push_back(n);
      end
      if (sFlush) begin
        expQ.delete();
        pc = $urandom_range(0, 1) ? 32'hBFC0_0380 : 32'h8000_0180;
        expQ.push_back(mk(pc));
      end else if (!sStall) begin
        pc = nextPc(pc);
        expQ.push_back(mk(pc));
      end
    end
  endtask

  logic        prevRst = 1'b1;
  logic        prevHold = 1'b0;
  logic [31:0] prevAddr = '0;
  int          lastAcc = 0;
  int          idle = 0;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      chk("rst_instReq", instReq, 0);
      chk("rst_instAddr", instAddr, 0);
      chk("rst_pcStall", pcStall, 1);
      chk("rst_instrValid", instrValid, 0);
      chk("rst_instr", instr, 0);
      chk("rst_instrPc", instrPc, 0);
      chk("rst_fetchAdEL", fetchAdEL, 0);
      lastAcc  = cyc;
      idle     = 0;
      prevHold = 1'b0;
    end else begin
      if (prevRst) chk("instrPc_after_reset", instrPc, RST_PC);
      if (prevHold) begin
        chk("req_held_until_ack", instReq, 1);
        chk("addr_held_until_ack", instAddr, prevAddr);
      end
      if (instReq) begin
        chk("addr_aligned", instAddr[1:0], 0);
        chk("single_outstanding", pending.size(), 0);
      end else begin
        chk("addr_zero_when_idle", instAddr, 0);
      end
      chk("no_req_while_valid", instrValid && instReq, 0);
      chk("no_valid_on_flush", instrValid && flush, 0);
      chk("adel_only_when_valid", fetchAdEL && !instrValid, 0);
      chk("pcStall", pcStall, !(instrValid && !idStall));
      if (instrValid) begin
        chk("instr_expected", expQ.size() != 0, 1);
        if (expQ.size() != 0) begin
          chk("instrPc", instrPc, expQ[0].pc);
          chk("instr", instr, expQ[0].word);
          chk("fetchAdEL", fetchAdEL, expQ[0].adel);
          if (!idStall) begin
            void'(expQ.pop_front());
            accepts++;
            if (mode == 0) chk("fast_path_gap", cyc - lastAcc, 3);
            lastAcc = cyc;
          end
        end
      end
      if (flush || (instrValid && !idStall)) idle = 0;
      else idle++;
      if (idle > 100) begin
        chk("progress_timeout", idle, 0);
        idle = 0;
      end
      prevHold = instReq && !instAck;
      prevAddr = instAddr;
    end
    prevRst = rst;
  end

  initial begin
    rst = 1'b1; pc = RST_PC; flush = 1'b0; idStall = 1'b0;
    instAck = 1'b0; instRValid = 1'b0; instRData = '0;
    mode = 0;
    repeat (4) step(1'b1);
    repeat (40) step(1'b0);
    mode = 1;
    for (int i = 0; i < 3000; i++) step(i >= 1500 && i < 1503);
    chk("enough_deliveries", accepts > 300, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the program counter against the instruction-memory bus.
- Issues one fetch per PC value and holds the PC via `pcStall` until the fetched word is accepted downstream.
- Presents the instruction to IF/ID.
- On exception or ERET redirect, abandons the in-flight fetch cleanly. The bus protocol is never violated, and stale responses are dropped.

Parameters:
- `RESET_PC`, default 32'hBFC0_0000: PC value that appears the cycle after reset. Used only for the reset value of `instrPc`.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `pc`  in  32  current PC from the PC register
- `flush`  in  1  exception or ERET taken this cycle; the PC redirects next cycle regardless of stall
- `idStall`  in  1  IF/ID cannot accept an instruction this cycle
- `instReq`  out  1  fetch request valid
- `instAddr`  out  32  fetch address; held stable while `instReq` && !`instAck`
- `instAck`  in  1  address accepted this cycle
- `instRValid`  in  1  read data valid; earliest one cycle after `instAck`
- `instRData`  in  32  read data
- `pcStall`  out  1  stall to the PC register
- `instr`  out  32  fetched instruction
- `instrValid`  out  1  `instr` is valid this cycle
- `instrPc`  out  32  address of `instr`
- `fetchAdEL`  out  1  `instrPc` is misaligned; `instr` = 0, and downstream raises AdEL

Behaviour:
- States: ISSUE, WAIT, HOLD, DRAIN_REQ, DRAIN_RESP.
- Reset:
  - state = ISSUE; `addrReg` = 0; `instrReg` = 0; `pcReg` = `RESET_PC`; `adelReg` = 0.
  - While `rst` is high, all outputs are forced to 0, except `pcStall` = 1.
- ISSUE:
  - If `pc[1:0]` != 0:
    - `instReq` = 0.
    - Latch `pcReg` <= `pc`, `instrReg` <= 0, `adelReg` <= 1.
    - Go to HOLD.
  - Otherwise:
    - `instReq` = 1, `instAddr` = `pc`; latch `addrReg` <= `pc` and `pcReg` <= `pc`.
    - `instAck` high -> WAIT; `instAck` low -> stay in ISSUE.
  - `flush` high in ISSUE:
    - `instReq` && `instAck` -> DRAIN_RESP.
    - `instReq` && !`instAck` -> DRAIN_REQ.
    - Misaligned case -> ISSUE. The next `pc` is the vector, so no drain is needed.
- WAIT:
  - `instReq` = 0.
  - `instRValid` -> `instrReg` <= `instRData`, `adelReg` <= 0, go to HOLD.
  - `flush` (with or without `instRValid`) -> DRAIN_RESP if `instRValid` is low; ISSUE if `instRValid` is high (response consumed and dropped).
- HOLD:
  - `instrValid` = !`flush`; `instr` = `instrReg`; `instrPc` = `pcReg`; `fetchAdEL` = `adelReg` && !`flush`.
  - !`flush` && !`idStall` -> instruction accepted: `pcStall` = 0 this cycle, go to ISSUE.
  - `flush` has priority over acceptance -> ISSUE.
- DRAIN_REQ:
  - `instReq` = 1, `instAddr` = `addrReg` (old address; the bus contract holds).
  - `instAck` -> DRAIN_RESP.
- DRAIN_RESP:
  - `instReq` = 0; wait for `instRValid`, discard the data, go to ISSUE.
- `pcStall` = 1 in every state and cycle except HOLD with !`flush` && !`idStall`.
  - Branch, jump, and sequential PC updates therefore happen only on the acceptance cycle.
  - Exception and ERET bypass `pcStall` inside the PC register.
- `flush` during DRAIN_REQ or DRAIN_RESP: no state change; the drain completes, then ISSUE fetches the latest `pc`.
- Outputs:
  - `instrValid` and `fetchAdEL` are 0 outside HOLD.
  - `instr` and `instrPc` hold their last registered values.
  - `instAddr` = 0 whenever `instReq` = 0.
- Throughput: one instruction per 3 cycles minimum (ISSUE-ack, WAIT-rvalid, HOLD-accept). No prefetch.
- `rst` asserted mid-operation returns to ISSUE immediately. Any outstanding bus transaction is the memory's responsibility; the memory is reset by the same `rst`.

Test Plan:
- Reset then run:
  - Stimulus: release `rst` with `pc` = BFC00000, `instAck` immediate, `instRValid` one cycle later with data 0x24080001, `idStall` = 0.
  - Required: `instReq`/`instAddr` = BFC00000; then `instrValid` = 1, `instr` = 0x24080001, `instrPc` = BFC00000, `pcStall` = 0 for exactly that cycle.
  - Then the next request goes to BFC00004.
- Downstream stall:
  - Stimulus: `idStall` = 1 for 4 cycles while in HOLD.
  - Required: `instrValid` held for 4 cycles with a constant `instr`; `pcStall` = 1 throughout; no new `instReq`.
  - `pcStall` drops in the cycle `idStall` falls.
- Flush before ack:
  - Stimulus: `instReq` to BFC00010 with `instAck` delayed 3 cycles; `flush` in cycle 1; `pc` becomes BFC00380.
  - Required: `instAddr` stays BFC00010 until ack; the response data is dropped (`instrValid` stays 0); the next request is BFC00380.
- Flush in WAIT and in HOLD:
  - Flush in WAIT: the late `instRValid` is discarded.
  - Flush in HOLD with `idStall` = 0: `instrValid` = 0 that cycle, then a request to the new `pc`.
- Misaligned PC:
  - Stimulus: `pc` = BFC00002.
  - Required: no `instReq`; next cycle `instrValid` = 1, `fetchAdEL` = 1, `instr` = 0, `instrPc` = BFC00002.
- Flush coincident with `instRValid` in WAIT:
  - Required: go straight to ISSUE; no DRAIN_RESP; no `instrValid` pulse.
